// File: rtl/inst_fetch_unit.sv
// Pipelined instruction fetch: in-order memory requests, fetch queue to decode, flush redirect.
// Optional IF_MISALIGN_TRAP_EN: a misaligned redirect target raises a sticky trap and halts fetch.
module inst_fetch_unit #(
  parameter int                  INST_WIDTH = 32,
  parameter int                  PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = {PC_WIDTH{1'b0}},
  parameter int                  FQ_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [PC_WIDTH-1:0]   imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  output logic [INST_WIDTH-1:0] inst,
  output logic [PC_WIDTH-1:0]   inst_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  input  logic                  IF_flush,
  input  logic [PC_WIDTH-1:0]   br_target,
  output logic                  fetch_misalign
);

  localparam int AW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0]           DEPTH_W = (CW+1)'(FQ_DEPTH);
  localparam logic [INST_WIDTH-1:0] NOP     = INST_WIDTH'(32'h0000_0013);
  localparam logic [PC_WIDTH-1:0]   PC_STEP = PC_WIDTH'(32'd4);

  logic [PC_WIDTH-1:0]   fetch_pc_r;
  logic [PC_WIDTH-1:0]   rsp_pc_r;
  logic [PC_WIDTH-1:0]   q_pc_r   [FQ_DEPTH];
  logic [INST_WIDTH-1:0] q_inst_r [FQ_DEPTH];
  logic [AW-1:0]         rd_ptr_r;
  logic [AW-1:0]         wr_ptr_r;
  logic [CW-1:0]         count_r;
  logic [CW-1:0]         live_cnt_r;
  logic [CW-1:0]         drop_cnt_r;
  logic                  run_r;
  logic                  misalign_r;

  logic [CW:0]           occ_s;
  logic [CW:0]           outst_s;
  logic                  req_valid_s;
  logic                  req_fire_s;
  logic                  rsp_live_s;
  logic                  rsp_drop_s;
  logic                  rsp_enq_s;
  logic                  head_valid_s;
  logic                  pop_s;
  logic [PC_WIDTH-1:0]   target_s;
  logic                  misalign_hit_s;

`ifdef IF_MISALIGN_TRAP_EN
  assign target_s       = br_target;
  assign misalign_hit_s = IF_flush & (br_target[1:0] != 2'b00);
`else
  assign target_s       = br_target & ~PC_WIDTH'(32'd3);
  assign misalign_hit_s = 1'b0;
`endif

  // Queue slots already promised (stored + live in flight) and total requests outstanding
  // both cap issue, so every kept response has a slot and drop_cnt cannot overflow.
  assign occ_s          = {1'b0, count_r} + {1'b0, live_cnt_r};
  assign outst_s        = {1'b0, live_cnt_r} + {1'b0, drop_cnt_r};
  assign req_valid_s    = run_r & ~IF_flush & ~misalign_r & (occ_s < DEPTH_W) & (outst_s < DEPTH_W);
  assign req_fire_s     = req_valid_s & imem_req_ready;
  assign rsp_live_s     = imem_rsp_valid & (drop_cnt_r == {CW{1'b0}});
  assign rsp_drop_s     = imem_rsp_valid & (drop_cnt_r != {CW{1'b0}});
  assign rsp_enq_s      = rsp_live_s & ~IF_flush;
  assign head_valid_s   = (count_r != {CW{1'b0}});
  assign pop_s          = head_valid_s & inst_ready & ~IF_flush;

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_r;
  assign inst_valid     = head_valid_s;
  assign inst           = head_valid_s ? q_inst_r[rd_ptr_r] : NOP;
  assign inst_pc        = head_valid_s ? q_pc_r[rd_ptr_r] : {PC_WIDTH{1'b0}};
  assign fetch_misalign = misalign_r;

  // Fetch/response PCs, queue pointers and outstanding-request bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_r <= RESET_PC;
      rsp_pc_r   <= RESET_PC;
      rd_ptr_r   <= {AW{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      live_cnt_r <= {CW{1'b0}};
      drop_cnt_r <= {CW{1'b0}};
      run_r      <= 1'b0;
      misalign_r <= 1'b0;
    end else begin
      run_r      <= 1'b1;
      misalign_r <= misalign_r | misalign_hit_s;
      if (IF_flush) begin
        fetch_pc_r <= target_s;
        rsp_pc_r   <= target_s;
        rd_ptr_r   <= {AW{1'b0}};
        wr_ptr_r   <= {AW{1'b0}};
        count_r    <= {CW{1'b0}};
        live_cnt_r <= {CW{1'b0}};
        // Whatever response lands now retires one outstanding request, kept or not.
        drop_cnt_r <= drop_cnt_r + live_cnt_r - CW'(imem_rsp_valid);
      end else begin
        if (req_fire_s) begin
          fetch_pc_r <= fetch_pc_r + PC_STEP;
        end
        if (rsp_enq_s) begin
          rsp_pc_r <= rsp_pc_r + PC_STEP;
          wr_ptr_r <= wr_ptr_r + AW'(1'b1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + AW'(1'b1);
        end
        if (rsp_drop_s) begin
          drop_cnt_r <= drop_cnt_r - CW'(1'b1);
        end
        live_cnt_r <= live_cnt_r + CW'(req_fire_s) - CW'(rsp_enq_s);
        count_r    <= count_r + CW'(rsp_enq_s) - CW'(pop_s);
      end
    end
  end

  // Fetch queue storage: kept responses are written with the PC they were fetched from.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FQ_DEPTH; i++) begin
        q_pc_r[i]   <= {PC_WIDTH{1'b0}};
        q_inst_r[i] <= {INST_WIDTH{1'b0}};
      end
    end else if (rsp_enq_s) begin
      q_pc_r[wr_ptr_r]   <= rsp_pc_r;
      q_inst_r[wr_ptr_r] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: latency-programmable memory model and
// an in-order scoreboard of expected {pc, inst} built from an independent PC tracker.
`timescale 1ns/1ps
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic        IF_flush = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        fetch_misalign;

  inst_fetch_unit dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .IF_flush(IF_flush), .br_target(br_target), .fetch_misalign(fetch_misalign)
  );

  always #5 clk = ~clk;

  typedef struct { int unsigned due; logic [31:0] data; } mem_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

  mem_t        mem_q[$];
  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_pop = 0;
  int unsigned cyc = 0;
  int unsigned last_due = 0;
  int unsigned mon_due;
  int unsigned lat = 1;
  logic [31:0] exp_addr = 32'h0;
  logic        trapped = 1'b0;
  exp_t        mon_e;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Memory response driver: presents the oldest response due at the coming edge.
  always @(negedge clk) begin
    #1;
    if (reset_n && mem_q.size() > 0 && mem_q[0].due == cyc + 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_q[0].data;
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
  end

  // Scoreboard: tracks expected fetch addresses, accepts requests, checks consumed instructions.
  always @(negedge clk) begin
    #3;
    if (!reset_n) begin
      mem_q.delete();
      exp_q.delete();
      exp_addr = 32'h0;
      last_due = 0;
      trapped  = 1'b0;
    end else begin
      if (IF_flush) begin
        exp_q.delete();
`ifdef IF_MISALIGN_TRAP_EN
        if (br_target[1:0] != 2'b00) trapped = 1'b1;
        exp_addr = br_target;
`else
        exp_addr = {br_target[31:2], 2'b00};
`endif
      end else if (inst_valid && inst_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got pc %h inst %h, expected no valid instruction", inst_pc, inst);
        end else begin
          mon_e = exp_q.pop_front();
          if (inst_pc !== mon_e.pc || inst !== mon_e.data) begin
            n_fail++;
            $display("FAIL sb_inst: got pc %h inst %h, expected pc %h inst %h", inst_pc, inst, mon_e.pc, mon_e.data);
          end
        end
        n_pop++;
      end
      if (imem_req_valid && imem_req_ready) begin
        n_checks++;
        if (trapped || IF_flush || imem_req_addr !== exp_addr) begin
          n_fail++;
          $display("FAIL sb_req_addr: got %h (trapped=%b flush=%b), expected %h", imem_req_addr, trapped, IF_flush, exp_addr);
        end
        mon_due = cyc + 1 + lat;
        if (mon_due <= last_due) mon_due = last_due + 1;
        last_due = mon_due;
        mem_q.push_back('{due: mon_due, data: memfn(imem_req_addr)});
        exp_q.push_back('{pc: exp_addr, data: memfn(exp_addr)});
        exp_addr = exp_addr + 32'd4;
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || fetch_misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got req_valid %b inst_valid %b misalign %b, expected 0 0 0", imem_req_valid, inst_valid, fetch_misalign);
    end
    n_checks++;
    if (inst !== 32'h0000_0013 || inst_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_head: got inst %h pc %h, expected 00000013 00000000", inst, inst_pc);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL first_req: got valid %b addr %h, expected 1 00000000", imem_req_valid, imem_req_addr);
    end
    @(negedge clk);
    n_checks++;
    if (inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL early_valid: got %b expected 0", inst_valid);
    end
    @(negedge clk);
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== memfn(32'h0)) begin
      n_fail++;
      $display("FAIL first_inst: got valid %b pc %h inst %h, expected 1 00000000 %h", inst_valid, inst_pc, inst, memfn(32'h0));
    end
  endtask

  task automatic test_random_ready();
    for (int i = 0; i < 30; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      inst_ready     = 1'($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_back_to_back(input int unsigned l);
    int p0;
    lat = l;
    repeat (8) @(negedge clk);
    p0 = n_pop;
    repeat (16) @(negedge clk);
    n_checks++;
    if (n_pop - p0 != 16) begin
      n_fail++;
      $display("FAIL back_to_back_lat%0d: got %0d pops in 16 cycles, expected 16", l, n_pop - p0);
    end
  endtask

  task automatic test_stall();
    inst_ready = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (inst_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_flags: got inst_valid %b req_valid %b, expected 1 0", inst_valid, imem_req_valid);
    end
    n_checks++;
    if (exp_q.size() != 4 || mem_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_depth: got %0d held %0d outstanding, expected 4 0", exp_q.size(), mem_q.size());
    end
    inst_ready = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_flush_inflight();
    bit found = 1'b0;
    lat = 3;
    IF_flush  = 1'b1;
    br_target = 32'h0000_0200;
    @(negedge clk);
    IF_flush = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = (mem_q.size() == 2 && exp_q.size() == 2);
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL flush_setup: got %0d outstanding, expected 2 within 10 cycles", mem_q.size());
    end
    IF_flush  = 1'b1;
    br_target = 32'h0000_0100;
    @(negedge clk);
    IF_flush = 1'b0;
    n_checks++;
    if (inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_empty: got inst_valid %b expected 0", inst_valid);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = inst_valid;
    end
    n_checks++;
    if (!found || inst_pc !== 32'h0000_0100 || inst !== memfn(32'h100)) begin
      n_fail++;
      $display("FAIL flush_target: got valid %b pc %h inst %h, expected 1 00000100 %h", found, inst_pc, inst, memfn(32'h100));
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_flush_rsp();
    bit seen = 1'b0;
    lat = 2;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      #2;
      seen = imem_rsp_valid;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL flush_rsp_setup: got no response within 10 cycles, expected one");
    end
    IF_flush   = 1'b1;
    br_target  = 32'h0000_0300;
    inst_ready = 1'b1;
    @(negedge clk);
    IF_flush = 1'b0;
    n_checks++;
    if (inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_rsp_empty: got inst_valid %b expected 0", inst_valid);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_wrap();
    bit found = 1'b0;
    lat = 1;
    IF_flush  = 1'b1;
    br_target = 32'hFFFF_FFF0;
    @(negedge clk);
    IF_flush = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = (inst_valid === 1'b1 && inst_pc === 32'h0);
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL pc_wrap: got last pc %h, expected 00000000 within 20 cycles", inst_pc);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_misalign();
    bit found = 1'b0;
    IF_flush  = 1'b1;
    br_target = 32'h0000_0102;
    @(negedge clk);
    IF_flush = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
    repeat (5) @(negedge clk);
    n_checks++;
    if (fetch_misalign !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_trap: got misalign %b req_valid %b inst_valid %b, expected 1 0 0", fetch_misalign, imem_req_valid, inst_valid);
    end
`else
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = inst_valid;
    end
    n_checks++;
    if (!found || inst_pc !== 32'h0000_0100 || fetch_misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_mask: got valid %b pc %h misalign %b, expected 1 00000100 0", found, inst_pc, fetch_misalign);
    end
`endif
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_random_ready();
    test_back_to_back(1);
    test_back_to_back(2);
    test_stall();
    test_flush_inflight();
    test_flush_rsp();
    test_wrap();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
